// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL save-counter control path.
package adpll_pkg;

    typedef enum logic [1:0] {
        S_DISABLED = 2'd0,
        S_ARM      = 2'd1,
        S_COUNT    = 2'd2
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/period_capture_ctrl_edge_sync.sv
// Asynchronous edge synchronizer with a single-cycle rise detector.
module edge_sync
    import adpll_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/period_capture_ctrl.sv
// Period counter FSM: measures trigger spacing and hands results
// to the loop filter over a valid/ready handshake.
module period_capture_ctrl
    import adpll_pkg::*;
#(
    parameter int WIDTH       = 20,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             fpga_clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             trigger_i,
    input  logic             period_ready_i,
    output logic [WIDTH-1:0] period_o,
    output logic             period_valid_o,
    output logic             period_ovf_o,
    output logic             overrun_o,
    output logic [WIDTH-1:0] count_o,
    output logic             counter_cleared_o,
    output logic             armed_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] period_q;
    logic             valid_q;
    logic             ovf_q;
    logic             overrun_q;
    logic             rise;
    logic             sat;
    logic             capture;
    logic [WIDTH-1:0] next_cnt;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_trig_sync (
        .clk_i  (fpga_clk_i),
        .reset_i(reset_i),
        .async_i(trigger_i),
        .rise_o (rise)
    );

    // The closing edge counts itself, hence count+1.
    assign sat      = (count_q == CNT_MAX);
    assign next_cnt = sat ? count_q : count_q + CNT_ONE;
    assign capture  = enable_i & rise & (state_q == S_COUNT);

    always_ff @(posedge fpga_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= S_DISABLED;
            count_q   <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (capture) begin
                period_q  <= next_cnt;
                ovf_q     <= sat;
                valid_q   <= 1'b1;
                overrun_q <= valid_q & ~period_ready_i;
            end else if (valid_q && period_ready_i) begin
                valid_q <= 1'b0;
            end

            if (!enable_i) begin
                state_q <= S_DISABLED;
                count_q <= '0;
            end else begin
                case (state_q)
                    S_DISABLED: begin
                        state_q <= S_ARM;
                        count_q <= '0;
                    end
                    S_ARM: begin
                        count_q <= '0;
                        if (rise) state_q <= S_COUNT;
                    end
                    S_COUNT: begin
                        count_q <= rise ? '0 : next_cnt;
                    end
                    default: begin
                        state_q <= S_DISABLED;
                        count_q <= '0;
                    end
                endcase
            end
        end
    end

    assign period_o          = period_q;
    assign period_valid_o    = valid_q;
    assign period_ovf_o      = ovf_q;
    assign overrun_o         = overrun_q;
    assign count_o           = count_q;
    assign counter_cleared_o = (count_q == '0);
    assign armed_o           = (state_q == S_ARM);

endmodule

// File: tb/tb_period_capture_ctrl.sv
// Directed bench for period_capture_ctrl (WIDTH=8).
module tb_period_capture_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         trig = 1'b0;
    logic         ready = 1'b0;
    logic [W-1:0] period;
    logic         valid;
    logic         ovf;
    logic         overrun;
    logic [W-1:0] count;
    logic         cleared;
    logic         armed;

    int total = 0;
    int passed = 0;

    int           got_n = 0;
    logic [W-1:0] got_p [32];
    logic         got_o [32];
    int           ovr_cnt = 0;
    int           vcyc = 0;

    typedef struct {
        int           p;
        logic [W-1:0] exp_p;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs [9];

    period_capture_ctrl #(
        .WIDTH(W),
        .SYNC_STAGES(2)
    ) dut (
        .fpga_clk_i       (clk),
        .reset_i          (rst_n),
        .enable_i         (enable),
        .trigger_i        (trig),
        .period_ready_i   (ready),
        .period_o         (period),
        .period_valid_o   (valid),
        .period_ovf_o     (ovf),
        .overrun_o        (overrun),
        .count_o          (count),
        .counter_cleared_o(cleared),
        .armed_o          (armed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) vcyc++;
        if (overrun) ovr_cnt++;
        if (valid && ready) begin
            if (got_n < 32) begin
                got_p[got_n] = period;
                got_o[got_n] = ovf;
            end
            got_n++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic edge_t();
        trig = 1'b1;
        cyc(1);
        trig = 1'b0;
    endtask

    task automatic fire(input int p);
        edge_t();
        cyc(p - 1);
    endtask

    task automatic restart(input logic rdy);
        rst_n  = 1'b0;
        enable = 1'b0;
        trig   = 1'b0;
        ready  = rdy;
        cyc(3);
        rst_n  = 1'b1;
        enable = 1'b1;
        cyc(2);
        got_n   = 0;
        ovr_cnt = 0;
        vcyc    = 0;
    endtask

    initial begin
        vecs[0] = '{100, 8'd100, 1'b0};
        vecs[1] = '{100, 8'd100, 1'b0};
        vecs[2] = '{100, 8'd100, 1'b0};
        vecs[3] = '{37,  8'd37,  1'b0};
        vecs[4] = '{255, 8'd255, 1'b0};
        vecs[5] = '{256, 8'd255, 1'b1};
        vecs[6] = '{300, 8'd255, 1'b1};
        vecs[7] = '{2,   8'd2,   1'b0};
        vecs[8] = '{3,   8'd3,   1'b0};

        // reset state
        cyc(2);
        chk("rst_period", int'(period), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_cleared", int'(cleared), 1);
        chk("rst_armed", int'(armed), 0);

        // table: ready tied high, arming edge yields no result
        restart(1'b1);
        chk("t1_armed", int'(armed), 1);
        for (int i = 0; i < 9; i++) fire(vecs[i].p);
        edge_t();
        cyc(6);
        chk("t1_nres", got_n, 9);
        chk("t1_vcyc", vcyc, 9);
        chk("t1_ovr", ovr_cnt, 0);
        for (int i = 0; i < 9; i++) begin
            if (i < got_n) begin
                chk($sformatf("t1_p%0d", i), int'(got_p[i]), int'(vecs[i].exp_p));
                chk($sformatf("t1_o%0d", i), int'(got_o[i]), int'(vecs[i].exp_ovf));
            end else begin
                chk($sformatf("t1_miss%0d", i), 0, 1);
            end
        end

        // counter saturates and holds at 255
        restart(1'b1);
        fire(10);
        edge_t();
        cyc(289);
        chk("sat_count", int'(count), 255);
        chk("sat_cleared", int'(cleared), 0);
        cyc(10);
        edge_t();
        cyc(6);
        chk("sat_nres", got_n, 2);
        if (got_n >= 2) begin
            chk("sat_p", int'(got_p[1]), 255);
            chk("sat_o", int'(got_o[1]), 1);
        end
        chk("sat_after", int'(count) < 10 ? 1 : 0, 1);

        // overrun with ready held low
        restart(1'b0);
        fire(50);
        edge_t();
        cyc(9);
        chk("ovr_v1", int'(valid), 1);
        chk("ovr_p1", int'(period), 50);
        chk("ovr_cnt1", ovr_cnt, 0);
        cyc(60);
        edge_t();
        cyc(9);
        chk("ovr_cnt2", ovr_cnt, 1);
        chk("ovr_p2", int'(period), 70);
        chk("ovr_v2", int'(valid), 1);
        chk("ovr_ovf2", int'(ovf), 0);

        // ready in the capture cycle: accept old, load new
        cyc(20);
        edge_t();
        cyc(1);
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
        chk("same_ovr", ovr_cnt, 1);
        chk("same_v", int'(valid), 1);
        chk("same_p", int'(period), 30);
        chk("same_n", got_n, 1);
        if (got_n >= 1) chk("same_old", int'(got_p[0]), 70);

        // enable dropped mid-count
        restart(1'b1);
        fire(40);
        cyc(20);
        enable = 1'b0;
        cyc(1);
        edge_t();
        cyc(4);
        chk("dis_armed", int'(armed), 0);
        chk("dis_count", int'(count), 0);
        chk("dis_valid", int'(valid), 0);
        enable = 1'b1;
        cyc(1);
        chk("rearm_armed", int'(armed), 1);
        chk("rearm_clr", int'(cleared), 1);
        fire(40);
        chk("cnt_armed", int'(armed), 0);
        fire(40);
        edge_t();
        cyc(5);
        chk("dis_nres", got_n, 2);
        if (got_n >= 1) chk("dis_p0", int'(got_p[0]), 40);

        // asynchronous reset mid-count with a result pending
        ready = 1'b0;
        edge_t();
        cyc(5);
        chk("ar_pre_v", int'(valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_count", int'(count), 0);
        chk("ar_cleared", int'(cleared), 1);
        chk("ar_valid", int'(valid), 0);
        chk("ar_period", int'(period), 0);
        chk("ar_armed", int'(armed), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/period_capture_ctrl.md
# period_capture_ctrl

Controller that sequences the ADPLL save-counter datapath: synchronizes an asynchronous trigger edge into the fpga_clk_i domain and runs a clear-on-trigger period counter. On each trigger it captures the elapsed cycle count and presents it to the loop filter/DCO update logic on a valid/ready handshake, reporting overflow and overrun. It sits between the reference/feedback edge sources and the digital loop filter.

## Interface
- WIDTH, 20, counter and result width in bits
- SYNC_STAGES, 2, trigger synchronizer depth (≥2)
- fpga_clk_i  in  1  system clock; all state on rising edge
- reset_i  in  1  asynchronous, active-low reset
- enable_i  in  1  measurement enable (synchronous level)
- trigger_i  in  1  asynchronous trigger; rising edge marks period boundary
- period_ready_i  in  1  consumer accepts period_o this cycle
- period_o  out  WIDTH  captured period in fpga_clk_i cycles
- period_valid_o  out  1  period_o holds an unconsumed result
- period_ovf_o  out  1  result saturated; qualified by period_valid_o
- overrun_o  out  1  one-cycle pulse: unconsumed result overwritten
- count_o  out  WIDTH  live counter value
- counter_cleared_o  out  1  high when count_o == 0 (combinational from counter register)
- armed_o  out  1  high in ARM state

## Operation
- Trigger path: SYNC_STAGES flops, then one edge-detect flop; rise = last sync stage high and edge flop low; single-cycle pulse.
- FSM states: DISABLED, ARM, COUNT.
  - DISABLED: counter held 0, rise ignored; enable_i=1 → ARM next cycle.
  - ARM: counter held 0; on rise → COUNT, counter cleared, no result produced.
  - COUNT: counter increments by 1 per cycle, saturating at 2^WIDTH−1; on rise: capture = count+1 (saturating), counter ← 0, ovf ← (count+1 would exceed 2^WIDTH−1).
  - enable_i=0 in any state → DISABLED next cycle; counter ← 0; pending result kept.
- Trigger edges spaced exactly P cycles apart give period_o = P; for P ≥ 2^WIDTH, period_o = 2^WIDTH−1 with period_ovf_o=1.
- Handshake: period_valid_o set on capture, cleared on period_valid_o & period_ready_i; period_o, period_ovf_o stable while valid and not accepted.
- Capture while valid & !ready: result overwritten, valid stays 1, overrun_o pulses 1 cycle.
- Capture while valid & ready same cycle: old accepted, new loaded, valid stays 1, no overrun.
- Rise coincident with enable_i falling: enable wins, no capture.

## Timing
- Reset values: state DISABLED, counter 0, period_o 0, period_valid_o 0, period_ovf_o 0, overrun_o 0, count_o 0, counter_cleared_o 1, armed_o 0, sync/edge flops 0.
- Trigger-to-result latency: trigger_i rising, sampled at clock edge k → rise pulse in cycle after edge k+SYNC_STAGES−1 → period_valid_o high after edge k+SYNC_STAGES.
- Pulses narrower than one clock period may be missed; no requirement.
- Reset deassertion mid-measurement: restart in DISABLED; no partial result emitted.
- Minimum trigger spacing: 2 cycles (each edge needs low-then-high at the sync output).

## Structure
- Shared package adpll_pkg: FSM state encodings (DISABLED=2'd0, ARM=2'd1, COUNT=2'd2) and default SYNC_STAGES.
- Sub-module edge_sync: SYNC_STAGES synchronizer + rise detector, async active-low reset, output rise pulse; reused for reference and feedback edges.
- Top contains FSM, saturating counter, result register, handshake.

## Test plan
- Reset, enable, triggers every 100 cycles, ready tied 1 → first edge no result; subsequent period_o = 100, ovf 0, valid one-cycle pulses.
- WIDTH=8, triggers 300 cycles apart → period_o = 255, period_ovf_o = 1; count_o sticks at 255 until edge.
- Ready held 0 across two captures (P=50 then P=70) → overrun_o one pulse at second capture, period_o = 70, valid held.
- Capture in same cycle as ready=1 with valid pending → no overrun, valid stays 1, period_o updates to new value.
- Drop enable_i mid-COUNT, re-enable, triggers at P=40 → no result for interrupted period; first post-ARM result = 40; armed_o high only in ARM.
- Assert reset_i=0 asynchronously mid-count → all outputs reset immediately, counter_cleared_o = 1.
